instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 104 ++++++++++
 tb/tb_instr_fetch.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: a four-state FSM that reads one instruction word from
// memory at pc, captures it for the instruction register and advances pc.
// A watchdog counter limits WAIT to TIMEOUT stalled cycles. On expiry the unit
// stays in ERR until reset.
module instr_fetch #(
  parameter logic [11:0] RESET_PC = 12'h000,
  parameter int          TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pc_load,
  input  logic [11:0] pc_target,
  output logic [11:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] instr,
  output logic        IRWrite,
  output logic [11:0] pc,
  output logic        busy,
  output logic        fetch_done,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    LOAD = 2'b10,
    ERR  = 2'b11
  } state_t;

  // The last stalled WAIT cycle is the one where the count already equals TIMEOUT-1.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic [7:0]  wait_cnt;

  // Advance the state register; reset returns to IDLE from any state, including ERR.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Choose the next state from the current state, start and memory handshake.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = WAIT;
      WAIT: begin
        if (mem_ready) begin
          state_next = LOAD;
        end else if (wait_cnt == LAST_WAIT) begin
          state_next = ERR;
        end
      end
      LOAD:    state_next = IDLE;
      ERR:     state_next = ERR;
      default: state_next = IDLE;
    endcase
  end

  // Update pc, the captured instruction and the watchdog. pc_target is loaded
  // in IDLE, so a combined start and pc_load fetches from the new address.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      instr    <= 16'h0000;
      wait_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= 8'd0;
          if (pc_load) pc <= pc_target;
        end
        WAIT: begin
          if (mem_ready) begin
            instr <= mem_rdata;
            pc    <= pc + 12'd1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from the state. pc does not change during WAIT, so it
  // doubles as a stable fetch address.
  always_comb begin
    mem_addr   = pc;
    mem_rd     = (state == WAIT);
    IRWrite    = (state == LOAD);
    fetch_done = (state == LOAD);
    fetch_err  = (state == ERR);
    busy       = (state != IDLE);
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios plus randomized fetches
// checked against a simple pc/instruction model kept in the bench.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic        start;
  logic        pc_load;
  logic [11:0] pc_target;
  logic [11:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] instr;
  logic        IRWrite;
  logic [11:0] pc;
  logic        busy;
  logic        fetch_done;
  logic        fetch_err;

  int n_cmp;
  int n_fail;
  logic [11:0] exp_pc;
  logic [15:0] exp_instr;

  instr_fetch #(.RESET_PC(12'h000), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .start(start), .pc_load(pc_load),
    .pc_target(pc_target), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .instr(instr),
    .IRWrite(IRWrite), .pc(pc), .busy(busy), .fetch_done(fetch_done),
    .fetch_err(fetch_err)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; pc_load = 1'b1; pc_target = 12'h7AB;
    mem_ready = 1'b1; mem_rdata = 16'hFFFF;
    tick();
    reset = 1'b0; start = 1'b0; pc_load = 1'b0; mem_ready = 1'b0;
    exp_pc = 12'h000; exp_instr = 16'h0000;
    n_cmp++; if (pc !== 12'h000) begin n_fail++; $display("[TB] FAIL reset_pc: got %h expected 000", pc); end
    n_cmp++; if (instr !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_instr: got %h expected 0000", instr); end
    n_cmp++; if ({IRWrite, mem_rd, fetch_done, fetch_err, busy} !== 5'b0)
      begin n_fail++; $display("[TB] FAIL reset_flags: got %b expected 00000", {IRWrite, mem_rd, fetch_done, fetch_err, busy}); end
  endtask

  task automatic test_basic_fetch();
    start = 1'b1;
    tick();
    start = 1'b0; mem_ready = 1'b1; mem_rdata = 16'hA5C3;
    n_cmp++; if ({mem_rd, busy, IRWrite} !== 3'b110) begin n_fail++; $display("[TB] FAIL basic_wait_flags: got %b expected 110", {mem_rd, busy, IRWrite}); end
    n_cmp++; if (mem_addr !== 12'h000) begin n_fail++; $display("[TB] FAIL basic_addr: got %h expected 000", mem_addr); end
    tick();
    mem_ready = 1'b0;
    n_cmp++; if ({IRWrite, fetch_done, mem_rd} !== 3'b110) begin n_fail++; $display("[TB] FAIL basic_load_flags: got %b expected 110", {IRWrite, fetch_done, mem_rd}); end
    n_cmp++; if (instr !== 16'hA5C3) begin n_fail++; $display("[TB] FAIL basic_instr: got %h expected a5c3", instr); end
    n_cmp++; if (pc !== 12'h001) begin n_fail++; $display("[TB] FAIL basic_pc: got %h expected 001", pc); end
    tick();
    n_cmp++; if ({IRWrite, fetch_done, busy} !== 3'b000) begin n_fail++; $display("[TB] FAIL basic_idle_flags: got %b expected 000", {IRWrite, fetch_done, busy}); end
    n_cmp++; if (instr !== 16'hA5C3) begin n_fail++; $display("[TB] FAIL basic_instr_hold: got %h expected a5c3", instr); end
    exp_pc = 12'h001; exp_instr = 16'hA5C3;
  endtask

  task automatic test_wait_states();
    int pulses;
    pulses = 0;
    start = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if ({mem_rd, fetch_err, IRWrite} !== 3'b100) begin n_fail++; $display("[TB] FAIL ws_flags_%0d: got %b expected 100", k, {mem_rd, fetch_err, IRWrite}); end
      n_cmp++; if (mem_addr !== exp_pc) begin n_fail++; $display("[TB] FAIL ws_addr_%0d: got %h expected %h", k, mem_addr, exp_pc); end
      start = 1'b1; pc_load = 1'b1; pc_target = 12'(~exp_pc);
      mem_ready = (k == 3); mem_rdata = 16'h1234;
      tick();
    end
    start = 1'b0; pc_load = 1'b0; mem_ready = 1'b0;
    exp_pc = exp_pc + 12'd1; exp_instr = 16'h1234;
    for (int k = 0; k < 3; k++) begin
      if (IRWrite === 1'b1) pulses++;
      n_cmp++; if (fetch_err !== 1'b0) begin n_fail++; $display("[TB] FAIL ws_err_%0d: got %b expected 0", k, fetch_err); end
      tick();
    end
    n_cmp++; if (pulses != 1) begin n_fail++; $display("[TB] FAIL ws_pulses: got %0d expected 1", pulses); end
    n_cmp++; if (pc !== exp_pc) begin n_fail++; $display("[TB] FAIL ws_pc: got %h expected %h", pc, exp_pc); end
    n_cmp++; if (instr !== exp_instr) begin n_fail++; $display("[TB] FAIL ws_instr: got %h expected %h", instr, exp_instr); end
  endtask

  task automatic test_redirect();
    start = 1'b1; pc_load = 1'b1; pc_target = 12'h3F0;
    tick();
    start = 1'b0; pc_target = 12'h123; mem_ready = 1'b0;
    n_cmp++; if (mem_addr !== 12'h3F0) begin n_fail++; $display("[TB] FAIL redir_addr: got %h expected 3f0", mem_addr); end
    tick();
    pc_load = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h0BAD;
    n_cmp++; if (mem_addr !== 12'h3F0) begin n_fail++; $display("[TB] FAIL redir_addr_hold: got %h expected 3f0", mem_addr); end
    tick();
    mem_ready = 1'b0;
    n_cmp++; if (pc !== 12'h3F1) begin n_fail++; $display("[TB] FAIL redir_pc: got %h expected 3f1", pc); end
    n_cmp++; if (instr !== 16'h0BAD) begin n_fail++; $display("[TB] FAIL redir_instr: got %h expected 0bad", instr); end
    tick();
    exp_pc = 12'h3F1; exp_instr = 16'h0BAD;
  endtask

  task automatic test_wrap();
    pc_load = 1'b1; pc_target = 12'hFFF;
    tick();
    pc_load = 1'b0;
    n_cmp++; if ({pc, busy} !== {12'hFFF, 1'b0}) begin n_fail++; $display("[TB] FAIL wrap_load: got pc=%h busy=%b expected fff 0", pc, busy); end
    start = 1'b1;
    tick();
    start = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h5A5A;
    n_cmp++; if (mem_addr !== 12'hFFF) begin n_fail++; $display("[TB] FAIL wrap_addr: got %h expected fff", mem_addr); end
    tick();
    mem_ready = 1'b0;
    n_cmp++; if (pc !== 12'h000) begin n_fail++; $display("[TB] FAIL wrap_pc: got %h expected 000", pc); end
    tick();
    exp_pc = 12'h000; exp_instr = 16'h5A5A;
  endtask

  task automatic test_timeout();
    int pulses;
    pulses = 0;
    start = 1'b1; mem_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      n_cmp++; if ({mem_rd, fetch_err} !== 2'b10) begin n_fail++; $display("[TB] FAIL to_wait_%0d: got %b expected 10", i, {mem_rd, fetch_err}); end
      tick();
    end
    n_cmp++; if ({fetch_err, mem_rd, IRWrite, busy} !== 4'b1001) begin n_fail++; $display("[TB] FAIL to_err_flags: got %b expected 1001", {fetch_err, mem_rd, IRWrite, busy}); end
    start = 1'b1; pc_load = 1'b1; pc_target = 12'h456; mem_ready = 1'b1; mem_rdata = 16'hDEAD;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (IRWrite === 1'b1) pulses++;
    end
    start = 1'b0; pc_load = 1'b0; mem_ready = 1'b0;
    n_cmp++; if ({fetch_err, pulses[0]} !== 2'b10 || pulses != 0) begin n_fail++; $display("[TB] FAIL to_sticky: got err=%b pulses=%0d expected 1 0", fetch_err, pulses); end
    n_cmp++; if ({pc, instr} !== {exp_pc, exp_instr}) begin n_fail++; $display("[TB] FAIL to_state_kept: got %h/%h expected %h/%h", pc, instr, exp_pc, exp_instr); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_pc = 12'h000; exp_instr = 16'h0000;
    n_cmp++; if ({fetch_err, busy, pc} !== {2'b00, 12'h000}) begin n_fail++; $display("[TB] FAIL to_reset: got err=%b busy=%b pc=%h expected 0 0 000", fetch_err, busy, pc); end
  endtask

  task automatic test_reset_mid_fetch();
    pc_load = 1'b1; pc_target = 12'h555; start = 1'b1;
    tick();
    pc_load = 1'b0; start = 1'b0;
    reset = 1'b1; mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    reset = 1'b0; mem_ready = 1'b0;
    n_cmp++; if ({busy, IRWrite, mem_rd} !== 3'b000) begin n_fail++; $display("[TB] FAIL rmid_flags: got %b expected 000", {busy, IRWrite, mem_rd}); end
    n_cmp++; if ({pc, instr} !== {12'h000, 16'h0000}) begin n_fail++; $display("[TB] FAIL rmid_state: got %h/%h expected 000/0000", pc, instr); end
    tick();
    n_cmp++; if (IRWrite !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid_no_irwrite: got %b expected 0", IRWrite); end
    exp_pc = 12'h000; exp_instr = 16'h0000;
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int idles;
      int delay;
      logic [15:0] data;
      idles = $urandom_range(0, 2);
      delay = $urandom_range(0, 5);
      data  = 16'($urandom);
      for (int i = 0; i < idles; i++) begin
        pc_load = 1'($urandom); pc_target = 12'($urandom);
        mem_ready = 1'($urandom); start = 1'b0;
        if (pc_load) exp_pc = pc_target;
        tick();
        n_cmp++; if ({pc, mem_addr, busy, mem_rd} !== {exp_pc, exp_pc, 2'b00}) begin n_fail++; $display("[TB] FAIL rnd_idle_%0d: got pc=%h addr=%h busy=%b rd=%b expected %h", n, pc, mem_addr, busy, mem_rd, exp_pc); end
        n_cmp++; if (instr !== exp_instr) begin n_fail++; $display("[TB] FAIL rnd_idle_instr_%0d: got %h expected %h", n, instr, exp_instr); end
      end
      start = 1'b1; pc_load = 1'($urandom); pc_target = 12'($urandom); mem_ready = 1'b0;
      if (pc_load) exp_pc = pc_target;
      tick();
      start = 1'b0;
      for (int d = 0; d <= delay; d++) begin
        n_cmp++; if ({mem_rd, mem_addr} !== {1'b1, exp_pc}) begin n_fail++; $display("[TB] FAIL rnd_wait_%0d: got rd=%b addr=%h expected 1 %h", n, mem_rd, mem_addr, exp_pc); end
        pc_load = 1'($urandom); pc_target = 12'($urandom); start = 1'($urandom);
        mem_ready = (d == delay); mem_rdata = (d == delay) ? data : 16'($urandom);
        tick();
      end
      start = 1'b0; pc_load = 1'b0; mem_ready = 1'($urandom);
      exp_pc = 12'((int'(exp_pc) + 1) % 4096); exp_instr = data;
      n_cmp++; if ({IRWrite, fetch_done, pc, instr} !== {2'b11, exp_pc, exp_instr}) begin n_fail++; $display("[TB] FAIL rnd_load_%0d: got ir=%b done=%b pc=%h instr=%h expected 1 1 %h %h", n, IRWrite, fetch_done, pc, instr, exp_pc, exp_instr); end
      tick();
      mem_ready = 1'b0;
      n_cmp++; if ({busy, IRWrite, fetch_err} !== 3'b000) begin n_fail++; $display("[TB] FAIL rnd_done_%0d: got %b expected 000", n, {busy, IRWrite, fetch_err}); end
    end
  endtask

  // Run the scenarios in order and report.
  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b1; start = 1'b0; pc_load = 1'b0; pc_target = 12'h000;
    mem_ready = 1'b0; mem_rdata = 16'h0000;
    exp_pc = 12'h000; exp_instr = 16'h0000;
    tick();
    test_reset();
    test_basic_fetch();
    test_wait_states();
    test_redirect();
    test_wrap();
    test_timeout();
    test_reset_mid_fetch();
    test_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
